// File: rtl/dot_product_seq_ctrl.sv
// dot_product_seq_ctrl: streams two unsigned vectors through one multiplier/accumulator and returns their dot product
module dot_product_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int MAX_LEN = 16,
    localparam int LEN_W = $clog2(MAX_LEN + 1),
    localparam int ACC_W = 2 * DATA_W + $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  result
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    state_t state, state_n;
    logic [LEN_W-1:0] cnt;
    logic [2*DATA_W-1:0] prod_reg;
    logic prod_vld;
    logic [ACC_W-1:0] acc;
    logic fire;
    logic [LEN_W-1:0] sat_len;
    assign fire = in_valid & in_ready;
    assign sat_len = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign result = acc;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // next-state and handshake outputs
    always_comb begin
        state_n = state;
        busy = state != IDLE;
        in_ready = state == LOAD;
        res_valid = state == DONE;
        case (state)
            IDLE:  state_n = start ? ((len == '0) ? DONE : LOAD) : IDLE;
            LOAD:  state_n = (fire && cnt == LEN_W'(1)) ? FLUSH : LOAD;
            FLUSH: state_n = DONE;
            DONE:  state_n = res_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    // two-stage multiply/accumulate datapath and element counter; a start clears the running sum
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            prod_reg <= '0;
            prod_vld <= 1'b0;
            acc <= '0;
        end else begin
            prod_vld <= fire;
            if (fire) prod_reg <= {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};
            if (state == IDLE && start) acc <= '0;
            else if (prod_vld) acc <= acc + ACC_W'(prod_reg);
            if (state == IDLE && start) cnt <= sat_len;
            else if (fire) cnt <= cnt - LEN_W'(1);
        end
    end
endmodule

// File: tb/tb_dot_product_seq_ctrl.sv
// tb_dot_product_seq_ctrl: randomized and directed jobs checked against a plain-arithmetic dot product model
module tb_dot_product_seq_ctrl;
    logic clk = 0;
    logic rst, start, in_valid, res_ready, busy, in_ready, res_valid;
    logic [4:0] len;
    logic [7:0] in_a, in_b;
    logic [19:0] result;
    int total = 0, bad = 0;
    int va[16], vb[16];
    dot_product_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .result(result)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic run_job(input int l, input int bub, input int hold, input bit fixed);
        int n, got, cyc;
        longint exp;
        n = (l > 16) ? 16 : l;
        exp = 0;
        got = 0;
        cyc = 0;
        if (!fixed)
            for (int i = 0; i < 16; i++) begin
                va[i] = $urandom_range(0, 255);
                vb[i] = $urandom_range(0, 255);
            end
        chk("idle_busy", busy, 0);
        start = 1;
        len = 5'(l);
        tick();
        start = 0;
        while (got < n && cyc < 2000) begin
            chk("load_ready", in_ready, 1);
            chk("load_busy", busy, 1);
            in_valid = ($urandom_range(0, 99) >= bub);
            in_a = in_valid ? 8'(va[got]) : 8'($urandom);
            in_b = in_valid ? 8'(vb[got]) : 8'($urandom);
            if (in_valid) begin
                exp += va[got] * vb[got];
                got++;
            end
            tick();
            cyc++;
        end
        if (got < n) chk("load_timeout", got, n);
        in_valid = 1;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        if (n > 0) begin
            chk("flush_ready", in_ready, 0);
            chk("flush_res_valid", res_valid, 0);
            tick();
        end
        exp = exp % (1 << 20);
        for (int c = 0; c <= hold; c++) begin
            chk("done_valid", res_valid, 1);
            chk("done_result", result, 32'(exp));
            chk("done_ready", in_ready, 0);
            start = $urandom_range(0, 1);
            len = 5'($urandom);
            res_ready = (c == hold);
            tick();
        end
        res_ready = 0;
        start = 0;
        in_valid = 0;
        chk("after_valid", res_valid, 0);
        chk("after_busy", busy, 0);
        chk("after_result", result, 32'(exp));
    endtask
    initial begin
        rst = 1;
        start = 0;
        len = 0;
        in_valid = 0;
        in_a = 0;
        in_b = 0;
        res_ready = 0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_result", result, 0);
        rst = 0;
        tick();
        for (int i = 0; i < 16; i++) begin
            va[i] = i + 1;
            vb[i] = i + 5;
        end
        run_job(4, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            va[i] = 255;
            vb[i] = 255;
        end
        run_job(16, 40, 0, 1);
        run_job(0, 0, 0, 0);
        run_job(31, 20, 0, 0);
        for (int i = 0; i < 16; i++) begin
            va[i] = i + 1;
            vb[i] = i + 5;
        end
        run_job(4, 0, 10, 1);
        start = 1;
        len = 4;
        tick();
        start = 0;
        in_valid = 1;
        in_a = 9;
        in_b = 9;
        repeat (2) tick();
        in_valid = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_result", result, 0);
        va[0] = 3;
        va[1] = 4;
        vb[0] = 10;
        vb[1] = 10;
        run_job(2, 0, 0, 1);
        va[0] = 200;
        vb[0] = 200;
        run_job(1, 0, 0, 1);
        repeat (30) run_job($urandom_range(0, 20), $urandom_range(0, 60), $urandom_range(0, 4), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dot_product_seq_ctrl.md
Name: dot_product_seq_ctrl

Overview:
Sequential dot-product controller that streams two unsigned vectors element-by-element through one shared multiplier and accumulator. Vector length is programmable per job, up to MAX_LEN. A start command opens a job, elements arrive over a valid/ready input handshake, and the final sum is returned over a valid/ready result handshake. It replaces a fully parallel fixed-length dot product wherever area matters more than throughput.

Parameters:
DATA_W, 8, element width of each operand (unsigned).
MAX_LEN, 16, maximum element pairs per job.
LEN_W, $clog2(MAX_LEN+1) = 5, width of the len port (derived; do not override).
ACC_W, 2*DATA_W+$clog2(MAX_LEN) = 20, accumulator/result width.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  job start command, sampled only in IDLE.
len  input  LEN_W  element-pair count for the job, sampled with start.
busy  output  1  high in every state except IDLE.
in_valid  input  1  element pair valid.
in_ready  output  1  controller accepts a pair.
in_a  input  DATA_W  vector a element.
in_b  input  DATA_W  vector b element.
res_valid  output  1  result valid.
res_ready  input  1  consumer accepts the result.
result  output  ACC_W  dot product sum.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, in_ready=0, res_valid=0, result=0; counter, product register and product-valid flag all cleared.
- Reset asserted mid-job aborts the job with no result. Elements already accepted are discarded.
- Arithmetic: unsigned DATA_W x DATA_W product, 2*DATA_W bits, zero-extended to ACC_W and added. Sum wraps modulo 2^ACC_W; no overflow with default parameters.
- Datapath pipeline:
  - Stage 1: on an accepted pair (in_valid & in_ready), prod_reg <= in_a*in_b and prod_vld <= 1; otherwise prod_vld <= 0.
  - Stage 2: whenever prod_vld=1, acc <= acc + prod_reg.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE (in_ready=0, res_valid=0):
  - start=1 and len!=0: acc <= 0, cnt <= min(len, MAX_LEN), go to LOAD.
  - start=1 and len=0: acc <= 0, go to DONE (result 0).
  - start=0: stay.
- LOAD (in_ready=1):
  - Each handshake decrements cnt.
  - Handshake while cnt==1 goes to FLUSH.
  - in_valid gaps (bubbles) are allowed and do not change cnt.
  - start is ignored.
- FLUSH (in_ready=0): one cycle; the last product is accumulated; go to DONE.
- DONE (res_valid=1, result=acc, held stable):
  - res_ready=1: res_valid falls next cycle and state returns to IDLE.
  - start is ignored, including in the cycle res_ready is high.
- len > MAX_LEN saturates to MAX_LEN elements.
- Latency:
  - Last pair accepted at edge T gives res_valid=1 from cycle T+2.
  - Best-case job of N elements: 1 (start) + N + 1 (flush) cycles to res_valid.
  - A new start is accepted one cycle after the result handshake.
- result holds the last completed value in IDLE until the next start clears acc; consumers qualify it with res_valid.
- Simultaneous events:
  - in_valid outside LOAD is ignored; no pair is consumed.
  - res_ready outside DONE has no effect.

Test Plan:
1. rst, then start with len=4; feed a=1,2,3,4 and b=5,6,7,8 back-to-back -> in_ready drops after the 4th pair; res_valid=1 two cycles later with result=70; res_ready=1 -> IDLE, busy=0.
2. len=16, all elements a=b=255 with random in_valid bubbles -> exactly 16 pairs accepted; result=1040400 (0xFE010); extra in_valid pulses after the 16th are not accepted.
3. start with len=0 -> res_valid next cycle, result=0, no pairs consumed; len=31 -> exactly 16 pairs accepted.
4. Result backpressure: hold res_ready=0 for 10 cycles -> res_valid and result=70 stay stable, in_ready=0; start pulses during DONE are ignored; release res_ready -> IDLE.
5. Reset mid-job: assert rst after 2 of 4 pairs -> next cycle all outputs are at reset values; a new job (len=2, a=3,4, b=10,10) returns result=70 with no residue from the aborted job.
6. Back-to-back jobs: start asserted in the cycle after the result handshake -> accepted; a second job of len=1 with a=200, b=200 gives result=40000.
